mlp_mover_nch: RTL and testbench
================================

# mlp_mover_nch

Parametrised successor to the single-layer BRAM data mover. On `i_run` it streams `i_num_cnt` packed words from one node BRAM and `NUM_CH` weight BRAMs over a shared read port and computes one signed dot product per channel. Each channel then adds its bias and the block holds the `NUM_CH` results for the host. It sits between the host-loaded BRAM bank and the result register file of the MLP datapath.

## Interface
- `NUM_CH`, 8, number of weight channels / results
- `CNT_BIT`, 31, width of `i_num_cnt`
- `DWIDTH`, 32, BRAM word width; must be a multiple of `IN_DATA_WIDTH`
- `AWIDTH`, 12, BRAM address width
- `MEM_SIZE`, 4096, BRAM depth in words
- `IN_DATA_WIDTH`, 8, signed lane width; `LANES = DWIDTH/IN_DATA_WIDTH`
- `ACC_WIDTH`, 32, accumulator, bias and result width
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `i_run`  in  1  start pulse, accepted only in IDLE
- `i_num_cnt`  in  CNT_BIT  words to process, sampled with `i_run`
- `o_idle`  out  1  state == IDLE
- `o_read`  out  1  state == READ
- `o_write`  out  1  state == DRAIN
- `o_done`  out  1  one-cycle pulse, state == DONE
- `o_addr`  out  AWIDTH  shared read address to node and weight BRAMs
- `o_ce`  out  1  shared chip enable
- `o_we`  out  1  constant 0
- `i_q_node`  in  DWIDTH  node BRAM read data, 1-cycle read latency
- `i_q_wgt`  in  NUM_CH*DWIDTH  weight BRAM read data; channel c at `[c*DWIDTH +: DWIDTH]`
- `i_bias`  in  NUM_CH*ACC_WIDTH  per-channel bias, two's complement, static during a run
- `o_result`  out  NUM_CH*ACC_WIDTH  per-channel result; channel c at `[c*ACC_WIDTH +: ACC_WIDTH]`

## Operation
- FSM states:
  - IDLE: waits for `i_run`.
  - READ: one address is issued per cycle, `o_ce`=1.
  - DRAIN: lasts 3 cycles to flush the pipeline.
  - DONE: lasts 1 cycle, then the FSM returns to IDLE.
- Transitions:
  - IDLE → READ on `i_run` if the latched count N > 0.
  - IDLE → DRAIN on `i_run` if N = 0.
  - READ → DRAIN after address N-1 has been issued.
- Count rule: N = min(`i_num_cnt`, `MEM_SIZE`). All accumulators clear when `i_run` is accepted.
- Addressing: addresses run 0..N-1 in order. `o_addr` and `o_ce` are 0 outside READ.
- Lanes: lane k of a word is `[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]` and is signed.
- Per-word partial sum for channel c: the sum over all lanes of node lane × weight lane, sign-extended to `ACC_WIDTH`.
- Accumulation: `acc[c] += psum[c]`, modulo 2^ACC_WIDTH. Wrap-around is silent and no saturation is applied.
- Result: `o_result[c] = acc[c] + i_bias[c]`, modulo 2^ACC_WIDTH. It is registered on the last DRAIN cycle and held until the next run's last DRAIN cycle or until reset.
- `i_run` outside IDLE is ignored, with no effect on the count, state or results.
- Reset values: state IDLE, `o_idle`=1, all other control outputs 0, `o_addr`=0, accumulators 0, `o_result`=0.
- Reset mid-run aborts immediately to the reset values. There is no partial result.

## Timing
- Cycle 0: `i_run`=1 sampled in IDLE.
- Cycles 1..N: READ with `o_addr` = cycle-1.
- Pipeline for the address issued in cycle t:
  - `i_q_*` is valid in cycle t+1.
  - `psum` is registered at the end of t+1.
  - `acc` is updated at the end of t+2.
  - Valid bits gate accumulation, so invalid pipeline slots never add.
- Cycles N+1..N+3: DRAIN. `o_result` is written at the end of N+3.
- Cycle N+4: DONE. `o_done`=1 and `o_result` is final.
- Cycle N+5: IDLE, `o_idle`=1.
- Latency from `i_run` to `o_done` is N+4 cycles; for N=0 it is 4 cycles.
- A new `i_run` is accepted from cycle N+5.

## Configuration
- `MLP_MOVER_RELU_EN`
  - Defined: each result is clamped at the result register; if the biased sum has its MSB set, `o_result[c]` = 0.
  - Undefined: the raw wrapped two's-complement sum is output.
  - The accumulators are unaffected either way.

## Test plan
- Basic dot product:
  - Setup: NUM_CH=2, N=1. Node word lanes {1,2,3,4}. Ch0 weights {1,1,1,1}, bias 5. Ch1 weights lanes 0xFF (-1), bias 0.
  - Required: `o_result` ch0=15; ch1=-10 (0xFFFFFFF6), or 0 with RELU_EN. `o_done` at cycle 5.
- Zero count: `i_num_cnt`=0, biases {7,-3} → no READ cycles, `o_ce` never asserted, results {7,-3}, `o_done` at cycle 4.
- Full depth with clamp:
  - Setup: `i_num_cnt`=5000, every lane 127 on node and weights, bias 0.
  - Required: exactly 4096 READ cycles with addresses 0..4095, result 264257536, `o_done` at cycle 4100.
- Wrap-around: ACC_WIDTH=16, N=1, all lanes 0x80, bias 0 → psum 65536 wraps, result 0.
- Busy and reset:
  - `i_run` pulsed during READ → ignored, results unchanged.
  - `reset_n` low in DRAIN → `o_idle`=1 and `o_result`=0 immediately, with no `o_done`.
  - A following run gives correct results.

Source files
------------

// File: rtl/mlp_mover_nch.sv
// mlp_mover_nch
// Streams N packed words from a node BRAM and NUM_CH weight BRAMs over one
// shared read port. It forms one signed dot product per channel, adds a
// per-channel bias, and holds the NUM_CH results for the host.
//
// Ports
//   clk, reset_n          single rising-edge clock, async active-low reset
//   i_run, i_num_cnt      start pulse (accepted only in IDLE) and word count
//   o_idle/o_read/o_write/o_done   FSM state flags (o_done is a 1-cycle pulse)
//   o_addr, o_ce, o_we    shared BRAM read port (o_we is tied low)
//   i_q_node, i_q_wgt     BRAM read data, valid one cycle after the address
//   i_bias                per-channel bias, ACC_WIDTH each
//   o_result              per-channel result, ACC_WIDTH each
//
// Build option
//   MLP_MOVER_RELU_EN     when defined, a result whose biased sum has its MSB
//                         set is stored as zero. The accumulators are not
//                         affected by this option.
module mlp_mover_nch #(
    parameter int NUM_CH        = 8,
    parameter int CNT_BIT       = 31,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 12,
    parameter int MEM_SIZE      = 4096,
    parameter int IN_DATA_WIDTH = 8,
    parameter int ACC_WIDTH     = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_run,
    input  logic [CNT_BIT-1:0]          i_num_cnt,
    output logic                        o_idle,
    output logic                        o_read,
    output logic                        o_write,
    output logic                        o_done,
    output logic [AWIDTH-1:0]           o_addr,
    output logic                        o_ce,
    output logic                        o_we,
    input  logic [DWIDTH-1:0]           i_q_node,
    input  logic [NUM_CH*DWIDTH-1:0]    i_q_wgt,
    input  logic [NUM_CH*ACC_WIDTH-1:0] i_bias,
    output logic [NUM_CH*ACC_WIDTH-1:0] o_result
);

    localparam int LANES = DWIDTH / IN_DATA_WIDTH;
    // One extra bit lets the count hold MEM_SIZE itself.
    localparam int CW    = AWIDTH + 1;
    localparam int PW    = 2 * IN_DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                        state, state_next;
    logic [CW-1:0]                 num_reg;
    logic [CW-1:0]                 num_in;
    logic [AWIDTH-1:0]             addr_reg;
    logic [1:0]                    drain_cnt;
    logic                          run_accept;
    logic                          last_addr;
    logic                          drain_last;
    logic                          q_valid;
    logic                          psum_valid;
    logic signed [PW-1:0]          lane_prod;
    logic signed [ACC_WIDTH-1:0]   psum_comb   [NUM_CH];
    logic signed [ACC_WIDTH-1:0]   psum_reg    [NUM_CH];
    logic signed [ACC_WIDTH-1:0]   acc         [NUM_CH];
    logic signed [ACC_WIDTH-1:0]   biased      [NUM_CH];
    logic        [ACC_WIDTH-1:0]   result_reg  [NUM_CH];

    assign run_accept = i_run && (state == S_IDLE);
    assign num_in     = (i_num_cnt > CNT_BIT'(MEM_SIZE)) ? CW'(MEM_SIZE) : CW'(i_num_cnt);
    assign last_addr  = (CW'(addr_reg) == (num_reg - CW'(1)));
    assign drain_last = (state == S_DRAIN) && (drain_cnt == 2'd2);
    assign o_we       = 1'b0;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero count skips READ and goes straight to the
    // drain so the result still becomes the bias alone.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (run_accept) state_next = (num_in == '0) ? S_DRAIN : S_READ;
            S_READ:  if (last_addr) state_next = S_DRAIN;
            S_DRAIN: if (drain_cnt == 2'd2) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic. The address is forced to zero outside READ.
    always_comb begin
        o_idle  = (state == S_IDLE);
        o_read  = (state == S_READ);
        o_write = (state == S_DRAIN);
        o_done  = (state == S_DONE);
        o_ce    = (state == S_READ);
        o_addr  = (state == S_READ) ? addr_reg : '0;
    end

    // Count latch, address counter and drain counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_reg   <= '0;
            addr_reg  <= '0;
            drain_cnt <= '0;
        end else begin
            if (run_accept) begin
                num_reg  <= num_in;
                addr_reg <= '0;
            end else if (state == S_READ) begin
                addr_reg <= addr_reg + AWIDTH'(1);
            end
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        end
    end

    // Per-channel partial sum of one word. Each lane product is formed at
    // full width and then cast to ACC_WIDTH, so the sum is exact modulo
    // 2^ACC_WIDTH even when ACC_WIDTH is narrow.
    always_comb begin
        lane_prod = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            psum_comb[c] = '0;
            for (int k = 0; k < LANES; k++) begin
                lane_prod = $signed(i_q_node[k*IN_DATA_WIDTH +: IN_DATA_WIDTH])
                          * $signed(i_q_wgt[c*DWIDTH + k*IN_DATA_WIDTH +: IN_DATA_WIDTH]);
                psum_comb[c] = psum_comb[c] + ACC_WIDTH'(lane_prod);
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            biased[c] = acc[c] + $signed(i_bias[c*ACC_WIDTH +: ACC_WIDTH]);
        end
    end

    // Pipeline. The read data for an address issued in READ is valid one
    // cycle later. The partial sum is registered in that cycle, and it is
    // accumulated in the cycle after that. The valid bits keep empty slots
    // from adding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_valid    <= 1'b0;
            psum_valid <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                psum_reg[c]   <= '0;
                acc[c]        <= '0;
                result_reg[c] <= '0;
            end
        end else begin
            q_valid    <= (state == S_READ);
            psum_valid <= q_valid;
            for (int c = 0; c < NUM_CH; c++) begin
                psum_reg[c] <= psum_comb[c];
                if (run_accept) begin
                    acc[c] <= '0;
                end else if (psum_valid) begin
                    acc[c] <= acc[c] + psum_reg[c];
                end
                if (drain_last) begin
`ifdef MLP_MOVER_RELU_EN
                    result_reg[c] <= biased[c][ACC_WIDTH-1] ? '0 : biased[c];
`else
                    result_reg[c] <= biased[c];
`endif
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign o_result[g*ACC_WIDTH +: ACC_WIDTH] = result_reg[g];
    end

endmodule

// File: tb/tb_mlp_mover_nch.sv
// Directed testbench for mlp_mover_nch.
// Instance A uses two channels of 32-bit results, and its BRAMs are modelled
// as 16-entry registered-read memories. Instance B uses one channel of 16-bit
// results and checks that the accumulator wraps.
module tb_mlp_mover_nch;

    logic        clk;
    logic        reset_n;

    // Instance A
    logic        a_run;
    logic [30:0] a_num;
    logic        a_idle, a_read, a_write, a_done, a_ce, a_we;
    logic [11:0] a_addr;
    logic [31:0] a_q_node;
    logic [63:0] a_q_wgt;
    logic [63:0] a_bias;
    logic [63:0] a_result;

    // Instance B
    logic        b_run;
    logic [30:0] b_num;
    logic        b_idle, b_read, b_write, b_done, b_ce, b_we;
    logic [11:0] b_addr;
    logic [31:0] b_q_node;
    logic [31:0] b_q_wgt;
    logic [15:0] b_bias;
    logic [15:0] b_result;
    logic [31:0] b_node_word;
    logic [31:0] b_wgt_word;

    logic [31:0] node_mem [16];
    logic [31:0] wgt0_mem [16];
    logic [31:0] wgt1_mem [16];

    int checks;
    int failures;

    mlp_mover_nch #(.NUM_CH(2)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_run     (a_run),
        .i_num_cnt (a_num),
        .o_idle    (a_idle),
        .o_read    (a_read),
        .o_write   (a_write),
        .o_done    (a_done),
        .o_addr    (a_addr),
        .o_ce      (a_ce),
        .o_we      (a_we),
        .i_q_node  (a_q_node),
        .i_q_wgt   (a_q_wgt),
        .i_bias    (a_bias),
        .o_result  (a_result)
    );

    mlp_mover_nch #(.NUM_CH(1), .ACC_WIDTH(16)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_run     (b_run),
        .i_num_cnt (b_num),
        .o_idle    (b_idle),
        .o_read    (b_read),
        .o_write   (b_write),
        .o_done    (b_done),
        .o_addr    (b_addr),
        .o_ce      (b_ce),
        .o_we      (b_we),
        .i_q_node  (b_q_node),
        .i_q_wgt   (b_q_wgt),
        .i_bias    (b_bias),
        .o_result  (b_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memory models with one cycle of latency
    always @(posedge clk) begin
        if (a_ce) begin
            a_q_node <= node_mem[a_addr[3:0]];
            a_q_wgt  <= {wgt1_mem[a_addr[3:0]], wgt0_mem[a_addr[3:0]]};
        end
        if (b_ce) begin
            b_q_node <= b_node_word;
            b_q_wgt  <= b_wgt_word;
        end
    end

    // Expected-result transform for the optional clamp
    function automatic logic [31:0] exp32(input logic [31:0] v);
`ifdef MLP_MOVER_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [15:0] exp16(input logic [15:0] v);
`ifdef MLP_MOVER_RELU_EN
        return v[15] ? 16'd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Runs instance A and reports the cycle index of o_done. Cycle 0 is the
    // cycle in which i_run is sampled. The task also counts READ cycles and
    // chip enables, and it counts addresses that differ from cycle-1.
    task automatic applyStimulus(input int count, input logic busy_pulse, input int max_cyc,
                                 output int done_cyc, output int read_cyc,
                                 output int ce_cyc, output int addr_err);
        int cyc;
        done_cyc = -1;
        read_cyc = 0;
        ce_cyc   = 0;
        addr_err = 0;
        cyc      = 0;
        @(negedge clk);
        a_run = 1'b1;
        a_num = 31'(count);
        while (done_cyc < 0 && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            a_run = 1'b0;
            if (busy_pulse && cyc == 2) begin
                a_run = 1'b1;
                a_num = 31'd1;
            end
            if (a_read) begin
                read_cyc++;
                if (int'(a_addr) != cyc - 1) addr_err++;
            end
            if (a_ce) ce_cyc++;
            if (a_done) done_cyc = cyc;
        end
        a_run = 1'b0;
    endtask

    task automatic runB(input int max_cyc, output int done_cyc);
        int cyc;
        done_cyc = -1;
        cyc      = 0;
        @(negedge clk);
        b_run = 1'b1;
        b_num = 31'd1;
        while (done_cyc < 0 && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            b_run = 1'b0;
            if (b_done) done_cyc = cyc;
        end
        b_run = 1'b0;
    endtask

    task automatic loadSmallPattern();
        for (int i = 0; i < 16; i++) begin
            node_mem[i] = 32'h05050505;
            wgt0_mem[i] = 32'h05050505;
            wgt1_mem[i] = 32'h05050505;
        end
        node_mem[0] = 32'h00000001;  wgt0_mem[0] = 32'h0000000A;  wgt1_mem[0] = 32'h000000FF;
        node_mem[1] = 32'h00000002;  wgt0_mem[1] = 32'h00000014;  wgt1_mem[1] = 32'h000000FF;
        node_mem[2] = 32'h00000003;  wgt0_mem[2] = 32'h0000001E;  wgt1_mem[2] = 32'h000000FF;
        node_mem[3] = 32'h00000064;  wgt0_mem[3] = 32'h00000001;  wgt1_mem[3] = 32'h000000FF;
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_cyc, read_cyc, ce_cyc, addr_err, guard, done_seen;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        a_run    = 1'b0;
        a_num    = '0;
        a_bias   = '0;
        b_run    = 1'b0;
        b_num    = '0;
        b_bias   = '0;
        b_node_word = '0;
        b_wgt_word  = '0;
        for (int i = 0; i < 16; i++) begin
            node_mem[i] = '0;
            wgt0_mem[i] = '0;
            wgt1_mem[i] = '0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_idle",   a_idle,   1);
        checkOutput("rst_read",   a_read,   0);
        checkOutput("rst_write",  a_write,  0);
        checkOutput("rst_done",   a_done,   0);
        checkOutput("rst_ce",     a_ce,     0);
        checkOutput("rst_we",     a_we,     0);
        checkOutput("rst_addr",   a_addr,   0);
        checkOutput("rst_result", a_result, 0);
        reset_n = 1'b1;

        // Basic dot product: ch0 = 1+2+3+4+5, ch1 = -(1+2+3+4)
        for (int i = 0; i < 16; i++) begin
            node_mem[i] = 32'h11111111;
            wgt0_mem[i] = 32'h22222222;
            wgt1_mem[i] = 32'h33333333;
        end
        node_mem[0] = 32'h04030201;
        wgt0_mem[0] = 32'h01010101;
        wgt1_mem[0] = 32'hFFFFFFFF;
        a_bias = {32'd0, 32'd5};
        applyStimulus(1, 1'b0, 20, done_cyc, read_cyc, ce_cyc, addr_err);
        checkOutput("basic_done_cyc", done_cyc, 5);
        checkOutput("basic_reads",    read_cyc, 1);
        checkOutput("basic_addr",     addr_err, 0);
        checkOutput("basic_ch0",      a_result[31:0],  exp32(32'd15));
        checkOutput("basic_ch1",      a_result[63:32], exp32(32'hFFFFFFF6));
        @(negedge clk);
        checkOutput("basic_idle_after", a_idle, 1);

        // Zero count: no reads, result equals bias
        a_bias = {32'hFFFFFFFD, 32'd7};
        applyStimulus(0, 1'b0, 20, done_cyc, read_cyc, ce_cyc, addr_err);
        checkOutput("zero_done_cyc", done_cyc, 4);
        checkOutput("zero_reads",    read_cyc, 0);
        checkOutput("zero_ce",       ce_cyc,   0);
        checkOutput("zero_ch0",      a_result[31:0],  exp32(32'd7));
        checkOutput("zero_ch1",      a_result[63:32], exp32(32'hFFFFFFFD));

        // Three words: ch0 = 10+40+90+1000, ch1 = -6-1; address 3 must not be read
        loadSmallPattern();
        a_bias = {32'hFFFFFFFF, 32'd1000};
        applyStimulus(3, 1'b0, 20, done_cyc, read_cyc, ce_cyc, addr_err);
        checkOutput("multi_done_cyc", done_cyc, 7);
        checkOutput("multi_reads",    read_cyc, 3);
        checkOutput("multi_addr",     addr_err, 0);
        checkOutput("multi_ch0",      a_result[31:0],  exp32(32'd1140));
        checkOutput("multi_ch1",      a_result[63:32], exp32(32'hFFFFFFF9));
        repeat (3) @(negedge clk);
        checkOutput("multi_held_ch0", a_result[31:0], exp32(32'd1140));

        // Full depth: 5000 is clamped to 4096 words of 4*127*127
        for (int i = 0; i < 16; i++) begin
            node_mem[i] = 32'h7F7F7F7F;
            wgt0_mem[i] = 32'h7F7F7F7F;
            wgt1_mem[i] = 32'h7F7F7F7F;
        end
        a_bias = '0;
        applyStimulus(5000, 1'b0, 4300, done_cyc, read_cyc, ce_cyc, addr_err);
        checkOutput("full_done_cyc", done_cyc, 4100);
        checkOutput("full_reads",    read_cyc, 4096);
        checkOutput("full_ce",       ce_cyc,   4096);
        checkOutput("full_addr",     addr_err, 0);
        checkOutput("full_ch0",      a_result[31:0],  exp32(32'd264257536));
        checkOutput("full_ch1",      a_result[63:32], exp32(32'd264257536));

        // i_run pulsed during READ is ignored
        loadSmallPattern();
        a_bias = {32'hFFFFFFFF, 32'd1000};
        applyStimulus(3, 1'b1, 20, done_cyc, read_cyc, ce_cyc, addr_err);
        checkOutput("busy_done_cyc", done_cyc, 7);
        checkOutput("busy_reads",    read_cyc, 3);
        checkOutput("busy_ch0",      a_result[31:0],  exp32(32'd1140));
        checkOutput("busy_ch1",      a_result[63:32], exp32(32'hFFFFFFF9));

        // Reset asserted during DRAIN aborts the run
        @(negedge clk);
        a_run = 1'b1;
        a_num = 31'd2;
        @(negedge clk);
        a_run = 1'b0;
        guard = 0;
        while (!a_write && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rstmid_in_drain", a_write, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("rstmid_idle",   a_idle,   1);
        checkOutput("rstmid_write",  a_write,  0);
        checkOutput("rstmid_result", a_result, 0);
        done_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (a_done) done_seen++;
        end
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (a_done) done_seen++;
        end
        checkOutput("rstmid_no_done", done_seen, 0);

        // A run after the abort gives correct results
        applyStimulus(3, 1'b0, 20, done_cyc, read_cyc, ce_cyc, addr_err);
        checkOutput("post_rst_done_cyc", done_cyc, 7);
        checkOutput("post_rst_ch0",      a_result[31:0],  exp32(32'd1140));
        checkOutput("post_rst_ch1",      a_result[63:32], exp32(32'hFFFFFFF9));

        // 16-bit accumulator: 4 * (-128 * -128) = 65536 wraps to 0
        b_node_word = 32'h80808080;
        b_wgt_word  = 32'h80808080;
        b_bias      = 16'd0;
        runB(20, done_cyc);
        checkOutput("wrap_done_cyc", done_cyc, 5);
        checkOutput("wrap_result",   b_result, exp16(16'h0000));

        // 16-bit accumulator: -128 + 3*16384 = 49024 = 0xBF80, plus bias 0x10
        b_wgt_word = 32'h80808001;
        b_bias     = 16'h0010;
        runB(20, done_cyc);
        checkOutput("wrap2_result", b_result, exp16(16'hBF90));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
